telemetry_framer: RTL and testbench

TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

---
 rtl/telemetry_framer.sv | 113 +++++++++++
 tb/tb_telemetry_framer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_framer.sv
// rtl/telemetry_framer.sv - byte-serialises a wheel-speed/pitch telemetry packet into a UART transmitter.
// Optional trailing checksum byte is built when TELEM_CHECKSUM_EN is defined.
module telemetry_framer #(
  parameter int BYTE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [15:0] lft_spd,
  input  logic [15:0] rght_spd,
  input  logic [15:0] ptch,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        pkt_done
);

`ifdef TELEM_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, SKIP, WAIT, GAP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [47:0] hold;
  logic [3:0]  idx;
  logic [7:0]  gap_cnt;
  logic [7:0]  cur_byte;
  logic        last_byte;

`ifdef TELEM_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign last_byte = (idx == LAST_IDX);
  assign busy      = (state != IDLE);

  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      4'd0: cur_byte = 8'hAA;
      4'd1: cur_byte = 8'h55;
      4'd2: cur_byte = hold[47:40];
      4'd3: cur_byte = hold[39:32];
      4'd4: cur_byte = hold[31:24];
      4'd5: cur_byte = hold[23:16];
      4'd6: cur_byte = hold[15:8];
      4'd7: cur_byte = hold[7:0];
`ifdef TELEM_CHECKSUM_EN
      4'd8: cur_byte = 8'h00 - csum;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (send) state_nxt = LOAD;
      LOAD: state_nxt = SKIP;
      // the transmitter's done flag is still stale while trmt is being seen
      SKIP: state_nxt = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (last_byte)         state_nxt = IDLE;
          else if (BYTE_GAP > 0) state_nxt = GAP;
          else                   state_nxt = LOAD;
        end
      end
      GAP: if (gap_cnt == 8'(BYTE_GAP - 1)) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= 48'h0;
      idx      <= 4'd0;
      gap_cnt  <= 8'd0;
      trmt     <= 1'b0;
      pkt_done <= 1'b0;
      tx_data  <= 8'h00;
`ifdef TELEM_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      state    <= state_nxt;
      trmt     <= (state == LOAD);
      pkt_done <= (state == WAIT) && tx_done && last_byte;
      gap_cnt  <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (state == IDLE && send) begin
        hold <= {lft_spd, rght_spd, ptch};
        idx  <= 4'd0;
`ifdef TELEM_CHECKSUM_EN
        csum <= 8'h00;
`endif
      end
      if (state == LOAD) begin
        tx_data <= cur_byte;
`ifdef TELEM_CHECKSUM_EN
        if (idx >= 4'd2 && idx <= 4'd7) csum <= csum + cur_byte;
`endif
      end
      if (state == WAIT && tx_done && !last_byte) idx <= idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// tb/tb_telemetry_framer.sv - self-checking bench for telemetry_framer (gap 0 and gap 5 instances side by side).
module tb_telemetry_framer;

  localparam int GAP1 = 5;
`ifdef TELEM_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [15:0] lft, rght, pt;
  logic        tx_done  [2];
  logic        trmt     [2];
  logic [7:0]  tx_data  [2];
  logic        busy     [2];
  logic        pkt_done [2];

  always #5 clk = ~clk;

  telemetry_framer #(.BYTE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .send(send), .lft_spd(lft), .rght_spd(rght), .ptch(pt),
    .tx_done(tx_done[0]), .trmt(trmt[0]), .tx_data(tx_data[0]), .busy(busy[0]), .pkt_done(pkt_done[0])
  );

  telemetry_framer #(.BYTE_GAP(GAP1)) dut1 (
    .clk(clk), .rst(rst), .send(send), .lft_spd(lft), .rght_spd(rght), .ptch(pt),
    .tx_done(tx_done[1]), .trmt(trmt[1]), .tx_data(tx_data[1]), .busy(busy[1]), .pkt_done(pkt_done[1])
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] p;
    logic [7:0]  cks;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         gaps      [2];
  bit         m_busy    [2];
  int         due_trmt  [2];
  int         due_done  [2];
  logic [7:0] exp_b     [2][9];
  int         exp_i     [2];
  int         ucnt      [2];
  bit         uclr      [2];
  logic [7:0] cap       [16];
  int         cap_n = 0;
  bit         scramble = 0;
  vec_t       tbl       [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference packet: fixed header, big-endian payload words, optional negated sum of payload bytes.
  task automatic build(input int d);
    logic [7:0] s;
    exp_b[d][0] = 8'hAA;        exp_b[d][1] = 8'h55;
    exp_b[d][2] = lft[15:8];    exp_b[d][3] = lft[7:0];
    exp_b[d][4] = rght[15:8];   exp_b[d][5] = rght[7:0];
    exp_b[d][6] = pt[15:8];     exp_b[d][7] = pt[7:0];
    s = 8'h00;
    for (int i = 2; i < 8; i++) s = s + exp_b[d][i];
    exp_b[d][8] = 8'h00 - s;
  endtask

  // One clock: apply model effects of the rising edge, check outputs, then run the UART model.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 0; due_trmt[d] = -1; due_done[d] = -1;
        chk("rst_tx_data", 32'(tx_data[d]), 32'h0);
      end else if (send && !m_busy[d]) begin
        build(d);
        m_busy[d] = 1; exp_i[d] = 0; due_trmt[d] = cyc + 1;
      end
      if (cyc == due_done[d]) m_busy[d] = 0;
      chk("trmt", 32'(trmt[d]), 32'(cyc == due_trmt[d]));
      chk("pkt_done", 32'(pkt_done[d]), 32'(cyc == due_done[d]));
      chk("busy", 32'(busy[d]), 32'(m_busy[d]));
      if (trmt[d]) begin
        if (exp_i[d] < NB) chk("tx_data", 32'(tx_data[d]), 32'(exp_b[d][exp_i[d]]));
        exp_i[d]++;
        if (d == 0 && cap_n < 16) begin cap[cap_n] = tx_data[0]; cap_n++; end
        uclr[d] = 1; ucnt[d] = 20;
      end else begin
        if (uclr[d]) begin tx_done[d] = 1'b0; uclr[d] = 0; end
        if (ucnt[d] > 0) begin
          ucnt[d]--;
          if (ucnt[d] == 0) begin
            tx_done[d] = 1'b1;
            if (m_busy[d]) begin
              if (exp_i[d] < NB) due_trmt[d] = cyc + gaps[d] + 2;
              else               due_done[d] = cyc + 1;
            end
          end
        end
      end
    end
    if (scramble) begin lft = 16'($urandom); rght = 16'($urandom); pt = 16'($urandom); end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_send();
    send = 1'b1; cycle(); send = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin cycle(); n++; end while ((busy[0] || busy[1]) && n < budget);
    chk("idle_timeout", 32'(busy[0] | busy[1]), 32'h0);
  endtask

  task automatic wait_cap(input int want, input int budget);
    int n = 0;
    while (cap_n < want && n < budget) begin cycle(); n++; end
    chk("cap_timeout", 32'(cap_n >= want), 32'h1);
  endtask

  initial begin
    logic [7:0] e [9];
    int n, dc;
    gaps[0] = 0; gaps[1] = GAP1;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; due_trmt[d] = -1; due_done[d] = -1;
      exp_i[d] = 0; ucnt[d] = 0; uclr[d] = 0; tx_done[d] = 1'b1;
    end
    tbl[0] = '{16'h1234, 16'hABCD, 16'h0F0F, 8'h24};
    tbl[1] = '{16'h0000, 16'h0000, 16'h0000, 8'h00};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h06};
    tbl[3] = '{16'h00AA, 16'h5500, 16'h0102, 8'hFE};
    tbl[4] = '{16'h8001, 16'h7FFF, 16'h0080, 8'h81};
    rst = 1'b1; send = 1'b1; lft = 16'h1111; rght = 16'h2222; pt = 16'h3333;

    // reset wins over a simultaneous send
    run(3);
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", 32'(busy[d]), 32'h0);
      chk("reset_trmt", 32'(trmt[d]), 32'h0);
      chk("reset_pkt_done", 32'(pkt_done[d]), 32'h0);
      chk("reset_tx_data", 32'(tx_data[d]), 32'h0);
    end
    rst = 1'b0; send = 1'b0;
    run(3);

    // table of directed packets; payload inputs churn after acceptance
    for (int v = 0; v < 5; v++) begin
      scramble = 0; cap_n = 0;
      lft = tbl[v].l; rght = tbl[v].r; pt = tbl[v].p;
      pulse_send();
      scramble = 1;
      wait_idle(1000);
      scramble = 0;
      e = '{8'hAA, 8'h55, tbl[v].l[15:8], tbl[v].l[7:0], tbl[v].r[15:8], tbl[v].r[7:0],
            tbl[v].p[15:8], tbl[v].p[7:0], tbl[v].cks};
      chk("tbl_count", 32'(cap_n), 32'(NB));
      for (int i = 0; i < NB; i++) chk("tbl_byte", 32'(cap[i]), 32'(e[i]));
      run(4);
    end

    // second send during byte 3 is dropped
    cap_n = 0; lft = 16'hC0DE; rght = 16'hBEEF; pt = 16'h7E57;
    pulse_send();
    wait_cap(4, 200);
    lft = 16'h0101; rght = 16'h0202; pt = 16'h0303;
    pulse_send();
    wait_idle(1000);
    run(40);
    chk("ignore_count", 32'(cap_n), 32'(NB));
    chk("ignore_lft_hi", 32'(cap[2]), 32'hC0);
    chk("ignore_ptch_lo", 32'(cap[7]), 32'h57);

    // reset while waiting on byte 4 aborts the packet
    cap_n = 0;
    pulse_send();
    wait_cap(5, 200);
    run(3);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("abort_trmt", 32'(trmt[0]), 32'h0);
    chk("abort_busy", 32'(busy[0]), 32'h0);
    run(30);
    chk("abort_no_more_bytes", 32'(cap_n), 32'h5);
    cap_n = 0; lft = 16'h5A5A; rght = 16'hA5A5; pt = 16'h0001;
    pulse_send();
    wait_idle(1000);
    chk("after_abort_count", 32'(cap_n), 32'(NB));
    chk("after_abort_first", 32'(cap[0]), 32'hAA);

    // send held high: next header byte two cycles after pkt_done
    send = 1'b1;
    n = 0;
    while (!pkt_done[0] && n < 400) begin cycle(); n++; end
    chk("b2b_done_timeout", 32'(pkt_done[0]), 32'h1);
    dc = cyc; n = 0;
    while (!trmt[0] && n < 10) begin cycle(); n++; end
    chk("b2b_latency", 32'(cyc - dc), 32'h2);
    chk("b2b_header", 32'(tx_data[0]), 32'hAA);
    run(600);
    send = 1'b0;
    wait_idle(1000);

    // randomized traffic with stray sends and occasional resets
    for (int it = 0; it < 25; it++) begin
      int lim;
      scramble = 0;
      lft = 16'($urandom); rght = 16'($urandom); pt = 16'($urandom);
      pulse_send();
      scramble = 1;
      lim = int'($urandom_range(40, 400));
      for (int c = 0; c < lim; c++) begin
        if ($urandom_range(0, 29) == 0) pulse_send();
        else if ($urandom_range(0, 499) == 0) begin
          rst = 1'b1; cycle(); rst = 1'b0; run(25);
        end else cycle();
      end
    end
    scramble = 0;
    wait_idle(1000);
    run(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
